// File: rtl/mux8_rr_arbiter_pkg.sv
// ============================================================================
// Module   : mux8_pkg
// Brief    : Shared sizes and state encoding for the Mux8 round-robin arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux8_pkg;

    localparam int NREQ = 8;
    localparam int SELW = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage : mux8_pkg

`default_nettype wire

// File: rtl/mux8_rr_arbiter_if.sv
// ============================================================================
// Module   : mux8_rr_arbiter_if
// Brief    : Request/grant bundle between the requesters and the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mux8_rr_arbiter_if;
    import mux8_pkg::*;

    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] grant;
    logic [SELW-1:0] sel;
    logic            valid;

    modport master (
        output req,
        output done,
        input  grant,
        input  sel,
        input  valid
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output sel,
        output valid
    );

endinterface : mux8_rr_arbiter_if

`default_nettype wire

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin winner search starting after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import mux8_pkg::*;
(
    input  wire logic [NREQ-1:0] req,
    input  wire logic [SELW-1:0] ptr,
    output logic                 found,
    output logic [SELW-1:0]      idx
);

    logic [SELW-1:0]   w_start;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [SELW-1:0]   w_off;

    // Rotating a doubled copy puts requester ptr+1 at bit 0, ptr at the top.
    assign w_start = ptr + 1'b1;
    assign w_dbl   = {req, req} >> w_start;
    assign w_rot   = w_dbl[NREQ-1:0];

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SELW'(i);
            end
        end
    end

    assign found = |w_rot;
    assign idx   = w_start + w_off;

endmodule : rr_pick

`default_nettype wire

// File: rtl/mux8_rr_arbiter.sv
// ============================================================================
// Module   : mux8_rr_arbiter
// Brief    : Round-robin arbiter with bounded hold driving a shared Mux8 select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux8_rr_arbiter
    import mux8_pkg::*;
#(
    parameter int MAXHOLD = 16,
    parameter int CNTW    = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mux8_rr_arbiter_if.slave  bus
);

    localparam logic [CNTW-1:0] C_HOLD_LAST = CNTW'(MAXHOLD - 1);

    state_t          r_state,    w_state_nxt;
    logic [SELW-1:0] r_ptr,      w_ptr_nxt;
    logic [CNTW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic [NREQ-1:0] r_grant,    w_grant_nxt;
    logic [SELW-1:0] r_sel,      w_sel_nxt;
    logic            r_valid,    w_valid_nxt;

    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic            w_release;

    rr_pick u_rr_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_release = bus.done | ~bus.req[r_sel] | (r_hold_cnt == C_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= SELW'(NREQ - 1);
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_grant_nxt    = r_grant;
        w_sel_nxt      = r_sel;
        w_valid_nxt    = r_valid;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ST_GRANT;
                    w_grant_nxt    = NREQ'(1) << w_idx;
                    w_sel_nxt      = w_idx;
                    w_ptr_nxt      = w_idx;
                    w_hold_cnt_nxt = '0;
                    w_valid_nxt    = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    // r_ptr already names the current grantee, so it ranks last here.
                    if (w_found) begin
                        w_grant_nxt    = NREQ'(1) << w_idx;
                        w_sel_nxt      = w_idx;
                        w_ptr_nxt      = w_idx;
                        w_hold_cnt_nxt = '0;
                        w_valid_nxt    = 1'b1;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_grant_nxt    = '0;
                        w_valid_nxt    = 1'b0;
                        w_hold_cnt_nxt = '0;
                    end
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.grant = r_grant;
    assign bus.sel   = r_sel;
    assign bus.valid = r_valid;

endmodule : mux8_rr_arbiter

`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux8_rr_arbiter
// Brief    : Directed table-driven bench for the Mux8 round-robin arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux8_rr_arbiter;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       done;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    bit   chk_on;
    vec_t vecs[$];

    mux8_rr_arbiter_if bus ();

    mux8_rr_arbiter #(
        .MAXHOLD (16),
        .CNTW    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] q, input logic d,
                       input logic [7:0] g, input logic [2:0] s, input logic v);
        vec_t x;
        x.rst_n = r; x.req = q; x.done = d;
        x.grant = g; x.sel = s; x.valid = v;
        vecs.push_back(x);
    endtask

    // Apply one cycle of inputs and compare the registered outputs after the edge.
    task automatic step(input string name, input logic r, input logic [7:0] q, input logic d,
                        input logic [7:0] g, input logic [2:0] s, input logic v);
        rst_n    = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.grant !== g || bus.sel !== s || bus.valid !== v) begin
            n_bad++;
            $display("FAIL %s: got grant=%h sel=%0d valid=%b, want grant=%h sel=%0d valid=%b",
                     name, bus.grant, bus.sel, bus.valid, g, s, v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic [2:0] ix;
            ix = '0;
            for (int i = 0; i < 8; i++) if (bus.grant[i]) ix = 3'(i);
            n_cmp++;
            if (!$onehot0(bus.grant) || (bus.valid !== (|bus.grant)) ||
                (bus.valid && bus.sel !== ix)) begin
                n_bad++;
                $display("FAIL invariant: got grant=%h sel=%0d valid=%b, want onehot0 grant, valid=|grant, sel=index",
                         bus.grant, bus.sel, bus.valid);
            end
        end
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        chk_on   = 1'b0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;

        // reset held with all requests high
        add(0, 8'hFF, 0, 8'h00, 0, 0);
        add(0, 8'hFF, 0, 8'h00, 0, 0);
        add(0, 8'hFF, 0, 8'h00, 0, 0);
        add(1, 8'hFF, 0, 8'h01, 0, 1);
        add(1, 8'h00, 0, 8'h00, 0, 0);
        // single request and drop
        add(1, 8'h20, 0, 8'h20, 5, 1);
        add(1, 8'h00, 0, 8'h00, 5, 0);
        // rotation between 7 and 0 with Done pulses
        add(1, 8'h81, 0, 8'h80, 7, 1);
        add(1, 8'h81, 1, 8'h01, 0, 1);
        add(1, 8'h81, 1, 8'h80, 7, 1);
        add(1, 8'h81, 1, 8'h01, 0, 1);
        add(1, 8'h81, 1, 8'h80, 7, 1);
        // grantee 3, then Done with Req[2] rising
        add(1, 8'h08, 0, 8'h08, 3, 1);
        add(1, 8'h0C, 1, 8'h04, 2, 1);
        add(1, 8'h04, 1, 8'h04, 2, 1);
        add(1, 8'h04, 0, 8'h04, 2, 1);
        add(1, 8'h00, 0, 8'h00, 2, 0);
        add(1, 8'h00, 1, 8'h00, 2, 0);
        add(1, 8'h04, 0, 8'h04, 2, 1);

        foreach (vecs[k]) begin
            step($sformatf("vec%0d", k), vecs[k].rst_n, vecs[k].req, vecs[k].done,
                 vecs[k].grant, vecs[k].sel, vecs[k].valid);
            if (vecs[k].rst_n) chk_on = 1'b1;
        end

        // timeout: 16 cycles each, alternating 1 and 2
        step("to_rst", 0, 8'h00, 0, 8'h00, 0, 0);
        for (int c = 0; c < 16; c++) step($sformatf("to_a%0d", c), 1, 8'h06, 0, 8'h02, 1, 1);
        for (int c = 0; c < 16; c++) step($sformatf("to_b%0d", c), 1, 8'h06, 0, 8'h04, 2, 1);
        step("to_back", 1, 8'h06, 0, 8'h02, 1, 1);

        // reset mid-grant at HoldCnt=9, then hold restarts from 0
        step("mg_rst", 0, 8'h00, 0, 8'h00, 0, 0);
        step("mg_g", 1, 8'h10, 0, 8'h10, 4, 1);
        for (int c = 0; c < 9; c++) step($sformatf("mg_h%0d", c), 1, 8'h10, 0, 8'h10, 4, 1);
        step("mg_rst2", 0, 8'h10, 0, 8'h00, 0, 0);
        step("mg_regrant", 1, 8'h10, 0, 8'h10, 4, 1);
        for (int c = 0; c < 15; c++) step($sformatf("mg_hold%0d", c), 1, 8'h11, 0, 8'h10, 4, 1);
        step("mg_switch", 1, 8'h11, 0, 8'h01, 0, 1);

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mux8_rr_arbiter

`default_nettype wire
